cpu_mem_req_seq: RTL and testbench
==================================

Name: cpu_mem_req_seq

Overview:
- Memory request sequencer that sits directly downstream of the CPU top level.
- Consumes the physical page number (PPN_23_10), cache address (CA_9_0), WRITE and store data (CD_15_0_OUT from the CPU).
- Runs a request/acknowledge cycle on the local memory bus, with a one-entry pending buffer and an acknowledge timeout.
- Returns read data plus a DT_n completion strobe to the CPU; a timeout raises IOXERR_n back to it.

Parameters:
- TIMEOUT_CYCLES, 64: WAIT-state cycles without MEM_ACK_n before the error path is taken; legal range 2..127.
- ERR_READ_DATA, 16'hFFFF: value returned on CD_15_0_OUT for a timed-out read.

Ports:
- sysclk  in  1  system clock; single clock domain.
- sys_rst_n  in  1  asynchronous, active-low reset.
- REQ  in  1  one-cycle request pulse from the CPU.
- WRITE  in  1  1 = write, 0 = read; sampled with REQ.
- PPN_23_10  in  14  physical page number; sampled with REQ.
- CA_9_0  in  10  word-in-page address; sampled with REQ.
- CD_15_0_IN  in  16  write data; sampled with REQ.
- MEM_ACK_n  in  1  memory acknowledge, active low.
- MEM_DATA_IN  in  16  memory read data; valid while MEM_ACK_n is low.
- MEM_ADDR  out  24  {PPN_23_10, CA_9_0} of the active request.
- MEM_DATA_OUT  out  16  write data of the active request.
- MEM_REQ_n  out  1  memory request, active low.
- MEM_WE_n  out  1  write enable, active low; valid while MEM_REQ_n is low.
- CD_15_0_OUT  out  16  read data returned to the CPU.
- DT_n  out  1  data-transferred strobe, low for one cycle.
- IOXERR_n  out  1  timeout error strobe, low for one cycle.
- BUSY  out  1  high whenever state is not IDLE or the pending slot is valid.
- OVF  out  1  sticky request-overflow flag.
- OVF_CLR  in  1  clears OVF.

Behaviour:
- Reset (asynchronous, active low): state IDLE; pending slot empty; timeout counter 0.
- Output reset values: MEM_REQ_n=1, MEM_WE_n=1, DT_n=1, IOXERR_n=1, BUSY=0, OVF=0, MEM_ADDR=0, MEM_DATA_OUT=0, CD_15_0_OUT=0.
- Reset mid-transfer abandons the transfer. No DT_n or IOXERR_n is produced for it.
- States: IDLE, ADDR, WAIT, DONE, ERR.
- IDLE: REQ=1 latches {PPN_23_10, CA_9_0}, CD_15_0_IN and WRITE into the active registers; next state ADDR.
- ADDR: MEM_REQ_n=0; MEM_WE_n=~WRITE_active; counter cleared; next state WAIT. MEM_ACK_n is ignored in ADDR.
- WAIT: MEM_REQ_n stays low and the counter increments each cycle.
  - MEM_ACK_n=0: a read captures MEM_DATA_IN into CD_15_0_OUT; next state DONE.
  - Counter == TIMEOUT_CYCLES-1 with no acknowledge: next state ERR.
  - Acknowledge in the same cycle as the timeout: acknowledge wins, next state DONE.
- DONE: DT_n=0 and MEM_REQ_n=1 for this one cycle.
- ERR: IOXERR_n=0 and MEM_REQ_n=1 for this one cycle. DT_n stays high. A read loads ERR_READ_DATA into CD_15_0_OUT.
- Exit from DONE/ERR, in priority order:
  - Pending slot valid: load it as active, go to ADDR.
  - Else REQ present this cycle: load REQ directly, go to ADDR.
  - Else go to IDLE.
- REQ while the state is not IDLE:
  - Pending slot empty: the request goes into the pending slot, except in DONE/ERR where the bypass rule above applies.
  - Pending slot full: the request is dropped and OVF is set.
  - REQ in DONE/ERR with the pending slot full: the pending entry becomes active and the new REQ is written into the pending slot. No overflow.
- CD_15_0_OUT holds its value until the next read completes. Writes leave it unchanged.
- OVF_CLR clears OVF. If OVF_CLR and an overflow occur in the same cycle, the set wins.
- Minimum latency, read with acknowledge in the first WAIT cycle: REQ at cycle 0, ADDR at cycle 1, WAIT at cycle 2, DT_n low at cycle 3.
- Back-to-back throughput: one request per 3 cycles.

Decomposition:
- Package cpu_memseq_pkg holds:
  - the state enum (IDLE/ADDR/WAIT/DONE/ERR);
  - a request struct {addr[23:0], data[15:0], write};
  - the default TIMEOUT_CYCLES and ERR_READ_DATA constants.
- Sub-module cpu_memseq_req_buf: the one-entry pending buffer.
  - Ports: push, pop, din, dout, valid, overflow.
  - Same sysclk / sys_rst_n.

Test Plan:
- Read, PPN=14'h0012, CA=10'h3A5, MEM_ACK_n low on the first WAIT cycle, MEM_DATA_IN=16'hBEEF -> MEM_ADDR=24'h004BA5; DT_n low exactly at cycle 3; CD_15_0_OUT=16'hBEEF; MEM_WE_n stays 1.
- Write, data 16'h1234, acknowledge after 5 WAIT cycles -> MEM_WE_n=0 for the whole ADDR+WAIT span; DT_n low once; CD_15_0_OUT unchanged.
- Read with MEM_ACK_n held high -> IOXERR_n low for one cycle after 64 WAIT cycles; CD_15_0_OUT=16'hFFFF; DT_n never low.
- Three REQ pulses on consecutive cycles while busy -> first two complete in order with two DT_n pulses; third dropped; OVF=1; OVF_CLR then OVF=0.
- REQ arriving in the DONE cycle with the pending slot empty -> goes straight to ADDR on the next cycle with no IDLE gap.
- sys_rst_n asserted during WAIT -> all outputs at reset values immediately (asynchronous); no DT_n after release; BUSY=0.

Source files
------------

// File: rtl/cpu_memseq_pkg.sv
// Shared types and defaults for the CPU memory request sequencer.
package cpu_memseq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    DONE,
    ERR
  } state_e;

  typedef struct packed {
    logic [23:0] addr;
    logic [15:0] data;
    logic        write;
  } mem_req_t;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 64;
  localparam logic [15:0] ERR_READ_DATA_DEF  = 16'hFFFF;
  localparam int unsigned CNT_W              = 7;

  function automatic mem_req_t pack_req(input logic [13:0] ppn,
                                        input logic [9:0]  ca,
                                        input logic [15:0] data,
                                        input logic        write);
    mem_req_t r;
    r.addr  = {ppn, ca};
    r.data  = data;
    r.write = write;
    return r;
  endfunction

endpackage

// File: rtl/cpu_memseq_req_buf.sv
// One-entry pending request slot; a push with pop in the same cycle replaces
// the entry, a push into a full slot without pop is dropped and flagged.
module cpu_memseq_req_buf
  import cpu_memseq_pkg::*;
(
  input  logic     sysclk,
  input  logic     sys_rst_n,
  input  logic     push,
  input  logic     pop,
  input  mem_req_t din,
  output mem_req_t dout,
  output logic     valid,
  output logic     overflow
);

  mem_req_t entry_q, entry_d;
  logic     valid_q, valid_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    entry_d = entry_q;
    valid_d = valid_q;
    if (pop) begin
      valid_d = 1'b0;
    end
    if (push && (!valid_q || pop)) begin
      entry_d = din;
      valid_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      valid_q <= 1'b0;
      // NOTE: the payload is reset only to keep bus outputs deterministic;
      // valid_q alone qualifies it.
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign dout     = entry_q;
  assign valid    = valid_q;
  assign overflow = push && valid_q && !pop;

endmodule

// File: rtl/cpu_mem_req_seq.sv
// Memory request sequencer: runs one REQ/ACK bus transfer at a time for the
// CPU, holds one pending request, and times out a silent memory.
module cpu_mem_req_seq
  import cpu_memseq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter logic [15:0] ERR_READ_DATA  = ERR_READ_DATA_DEF
) (
  input  logic        sysclk,
  input  logic        sys_rst_n,
  input  logic        REQ,
  input  logic        WRITE,
  input  logic [13:0] PPN_23_10,
  input  logic [9:0]  CA_9_0,
  input  logic [15:0] CD_15_0_IN,
  input  logic        MEM_ACK_n,
  input  logic [15:0] MEM_DATA_IN,
  output logic [23:0] MEM_ADDR,
  output logic [15:0] MEM_DATA_OUT,
  output logic        MEM_REQ_n,
  output logic        MEM_WE_n,
  output logic [15:0] CD_15_0_OUT,
  output logic        DT_n,
  output logic        IOXERR_n,
  output logic        BUSY,
  output logic        OVF,
  input  logic        OVF_CLR
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  mem_req_t         act_q, act_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      cd_q, cd_d;
  logic             ovf_q, ovf_d;

  mem_req_t req_in;
  mem_req_t buf_dout;
  logic     buf_push, buf_pop, buf_valid, buf_ovf;
  logic     bus_active;

  assign req_in = pack_req(PPN_23_10, CA_9_0, CD_15_0_IN, WRITE);

  cpu_memseq_req_buf u_req_buf (
    .sysclk    (sysclk),
    .sys_rst_n (sys_rst_n),
    .push      (buf_push),
    .pop       (buf_pop),
    .din       (req_in),
    .dout      (buf_dout),
    .valid     (buf_valid),
    .overflow  (buf_ovf)
  );

  always_comb begin
    state_d  = state_q;
    act_d    = act_q;
    cnt_d    = cnt_q;
    cd_d     = cd_q;
    ovf_d    = ovf_q;
    buf_push = 1'b0;
    buf_pop  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (REQ) begin
          act_d   = req_in;
          state_d = ADDR;
        end
      end

      ADDR: begin
        buf_push = REQ;
        cnt_d    = '0;
        state_d  = WAIT;
      end

      WAIT: begin
        buf_push = REQ;
        // Acknowledge takes priority over a timeout landing in the same cycle.
        if (!MEM_ACK_n) begin
          if (!act_q.write) cd_d = MEM_DATA_IN;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          if (!act_q.write) cd_d = ERR_READ_DATA;
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE, ERR: begin
        // The pending entry is older, so it goes first; a fresh REQ then
        // refills the slot it vacates. With the slot empty, REQ bypasses it.
        if (buf_valid) begin
          act_d    = buf_dout;
          buf_pop  = 1'b1;
          buf_push = REQ;
          state_d  = ADDR;
        end else if (REQ) begin
          act_d   = req_in;
          state_d = ADDR;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (OVF_CLR) ovf_d = 1'b0;
    if (buf_ovf) ovf_d = 1'b1;
  end

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      act_q   <= '0;
      cnt_q   <= '0;
      cd_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      cnt_q   <= cnt_d;
      cd_q    <= cd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus_active   = (state_q == ADDR) || (state_q == WAIT);
  assign MEM_REQ_n    = !bus_active;
  assign MEM_WE_n     = !(bus_active && act_q.write);
  assign MEM_ADDR     = act_q.addr;
  assign MEM_DATA_OUT = act_q.data;
  assign CD_15_0_OUT  = cd_q;
  assign DT_n         = (state_q != DONE);
  assign IOXERR_n     = (state_q != ERR);
  assign BUSY         = (state_q != IDLE) || buf_valid;
  assign OVF          = ovf_q;

endmodule

// File: tb/tb_cpu_mem_req_seq.sv
// Directed bench for cpu_mem_req_seq: read, write, timeout, overflow,
// DONE-cycle bypass and asynchronous reset mid-transfer.
module tb_cpu_mem_req_seq;

  logic        sysclk = 1'b0;
  logic        sys_rst_n;
  logic        REQ, WRITE, MEM_ACK_n, OVF_CLR;
  logic [13:0] PPN_23_10;
  logic [9:0]  CA_9_0;
  logic [15:0] CD_15_0_IN, MEM_DATA_IN;
  logic [23:0] MEM_ADDR;
  logic [15:0] MEM_DATA_OUT, CD_15_0_OUT;
  logic        MEM_REQ_n, MEM_WE_n, DT_n, IOXERR_n, BUSY, OVF;

  int errors = 0;
  int checks = 0;

  cpu_mem_req_seq dut (
    .sysclk       (sysclk),
    .sys_rst_n    (sys_rst_n),
    .REQ          (REQ),
    .WRITE        (WRITE),
    .PPN_23_10    (PPN_23_10),
    .CA_9_0       (CA_9_0),
    .CD_15_0_IN   (CD_15_0_IN),
    .MEM_ACK_n    (MEM_ACK_n),
    .MEM_DATA_IN  (MEM_DATA_IN),
    .MEM_ADDR     (MEM_ADDR),
    .MEM_DATA_OUT (MEM_DATA_OUT),
    .MEM_REQ_n    (MEM_REQ_n),
    .MEM_WE_n     (MEM_WE_n),
    .CD_15_0_OUT  (CD_15_0_OUT),
    .DT_n         (DT_n),
    .IOXERR_n     (IOXERR_n),
    .BUSY         (BUSY),
    .OVF          (OVF),
    .OVF_CLR      (OVF_CLR)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic drive_req(input logic w, input logic [13:0] ppn, input logic [9:0] ca,
                           input logic [15:0] d);
    REQ        = 1'b1;
    WRITE      = w;
    PPN_23_10  = ppn;
    CA_9_0     = ca;
    CD_15_0_IN = d;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_n"}, MEM_REQ_n, 1'b1);
    check({tag, "_we_n"}, MEM_WE_n, 1'b1);
    check({tag, "_dt_n"}, DT_n, 1'b1);
    check({tag, "_iox_n"}, IOXERR_n, 1'b1);
    check({tag, "_busy"}, BUSY, 1'b0);
    check({tag, "_ovf"}, OVF, 1'b0);
    check({tag, "_addr"}, MEM_ADDR, 24'h0);
    check({tag, "_dout"}, MEM_DATA_OUT, 16'h0);
    check({tag, "_cd"}, CD_15_0_OUT, 16'h0);
  endtask

  initial begin
    sys_rst_n   = 1'b0;
    REQ         = 1'b0;
    WRITE       = 1'b0;
    PPN_23_10   = '0;
    CA_9_0      = '0;
    CD_15_0_IN  = '0;
    MEM_ACK_n   = 1'b1;
    MEM_DATA_IN = '0;
    OVF_CLR     = 1'b0;
    #2;
    check_reset_outputs("rst");
    @(negedge sysclk);
    sys_rst_n = 1'b1;
    tick();

    // Read, acknowledge already low during ADDR (must be ignored there).
    drive_req(1'b0, 14'h0012, 10'h3A5, 16'h0);
    tick();
    REQ = 1'b0;
    check("rd_c1_req_n", MEM_REQ_n, 1'b0);
    check("rd_c1_addr", MEM_ADDR, 24'h004BA5);
    check("rd_c1_we_n", MEM_WE_n, 1'b1);
    check("rd_c1_dt_n", DT_n, 1'b1);
    check("rd_c1_busy", BUSY, 1'b1);
    MEM_ACK_n   = 1'b0;
    MEM_DATA_IN = 16'hBEEF;
    tick();
    check("rd_c2_req_n", MEM_REQ_n, 1'b0);
    check("rd_c2_we_n", MEM_WE_n, 1'b1);
    check("rd_c2_dt_n", DT_n, 1'b1);
    tick();
    check("rd_c3_dt_n", DT_n, 1'b0);
    check("rd_c3_req_n", MEM_REQ_n, 1'b1);
    check("rd_c3_cd", CD_15_0_OUT, 16'hBEEF);
    MEM_ACK_n = 1'b1;
    tick();
    check("rd_c4_dt_n", DT_n, 1'b1);
    check("rd_c4_busy", BUSY, 1'b0);

    // Write, acknowledge on the sixth WAIT cycle.
    drive_req(1'b1, 14'h3FFF, 10'h000, 16'h1234);
    tick();
    REQ = 1'b0;
    check("wr_addr", MEM_ADDR, 24'hFFFC00);
    check("wr_dout", MEM_DATA_OUT, 16'h1234);
    check("wr_adr_we_n", MEM_WE_n, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("wr_wait_we_n", MEM_WE_n, 1'b0);
      check("wr_wait_req_n", MEM_REQ_n, 1'b0);
      check("wr_wait_dt_n", DT_n, 1'b1);
      tick();
    end
    MEM_ACK_n   = 1'b0;
    MEM_DATA_IN = 16'h5555;
    check("wr_ack_we_n", MEM_WE_n, 1'b0);
    tick();
    MEM_ACK_n = 1'b1;
    check("wr_done_dt_n", DT_n, 1'b0);
    check("wr_done_we_n", MEM_WE_n, 1'b1);
    check("wr_done_cd", CD_15_0_OUT, 16'hBEEF);
    tick();
    check("wr_idle_dt_n", DT_n, 1'b1);
    check("wr_idle_busy", BUSY, 1'b0);

    // Read timeout after 64 WAIT cycles.
    drive_req(1'b0, 14'h0155, 10'h2AA, 16'h0);
    tick();
    REQ = 1'b0;
    check("to_addr", MEM_ADDR, 24'h0556AA);
    tick();
    for (int i = 0; i < 64; i++) begin
      check("to_wait_iox_n", IOXERR_n, 1'b1);
      check("to_wait_dt_n", DT_n, 1'b1);
      check("to_wait_req_n", MEM_REQ_n, 1'b0);
      tick();
    end
    check("to_err_iox_n", IOXERR_n, 1'b0);
    check("to_err_dt_n", DT_n, 1'b1);
    check("to_err_req_n", MEM_REQ_n, 1'b1);
    tick();
    check("to_post_iox_n", IOXERR_n, 1'b1);
    check("to_post_dt_n", DT_n, 1'b1);
    check("to_post_cd", CD_15_0_OUT, 16'hFFFF);
    check("to_post_busy", BUSY, 1'b0);

    // Three back-to-back REQs: A runs, B pends, C overflows.
    drive_req(1'b0, 14'h0001, 10'h001, 16'h0);
    tick();
    drive_req(1'b0, 14'h0002, 10'h002, 16'h0);
    tick();
    drive_req(1'b0, 14'h0003, 10'h003, 16'h0);
    tick();
    REQ = 1'b0;
    check("ov_ovf_set", OVF, 1'b1);
    check("ov_a_addr", MEM_ADDR, 24'h000401);
    check("ov_busy", BUSY, 1'b1);
    MEM_ACK_n   = 1'b0;
    MEM_DATA_IN = 16'h1111;
    tick();
    MEM_ACK_n = 1'b1;
    check("ov_a_dt_n", DT_n, 1'b0);
    check("ov_a_cd", CD_15_0_OUT, 16'h1111);
    tick();
    check("ov_b_req_n", MEM_REQ_n, 1'b0);
    check("ov_b_addr", MEM_ADDR, 24'h000802);
    check("ov_b_dt_n", DT_n, 1'b1);
    tick();
    MEM_ACK_n   = 1'b0;
    MEM_DATA_IN = 16'h2222;
    tick();
    MEM_ACK_n = 1'b1;
    check("ov_b_dt_n_low", DT_n, 1'b0);
    check("ov_b_cd", CD_15_0_OUT, 16'h2222);
    tick();
    check("ov_end_busy", BUSY, 1'b0);
    check("ov_end_req_n", MEM_REQ_n, 1'b1);
    check("ov_end_ovf", OVF, 1'b1);
    OVF_CLR = 1'b1;
    tick();
    OVF_CLR = 1'b0;
    check("ov_clr", OVF, 1'b0);

    // REQ during DONE with an empty slot goes straight to ADDR.
    drive_req(1'b0, 14'h0000, 10'h3FF, 16'h0);
    tick();
    REQ = 1'b0;
    tick();
    MEM_ACK_n   = 1'b0;
    MEM_DATA_IN = 16'h0A0A;
    tick();
    MEM_ACK_n = 1'b1;
    check("byp_d_dt_n", DT_n, 1'b0);
    check("byp_d_cd", CD_15_0_OUT, 16'h0A0A);
    drive_req(1'b1, 14'h2AAA, 10'h155, 16'hCAFE);
    tick();
    REQ = 1'b0;
    check("byp_e_req_n", MEM_REQ_n, 1'b0);
    check("byp_e_addr", MEM_ADDR, 24'hAAA955);
    check("byp_e_we_n", MEM_WE_n, 1'b0);
    check("byp_e_dout", MEM_DATA_OUT, 16'hCAFE);
    check("byp_e_busy", BUSY, 1'b1);
    tick();
    MEM_ACK_n = 1'b0;
    tick();
    MEM_ACK_n = 1'b1;
    check("byp_e_dt_n", DT_n, 1'b0);
    check("byp_e_cd", CD_15_0_OUT, 16'h0A0A);
    tick();

    // Asynchronous reset during WAIT.
    drive_req(1'b1, 14'h1111, 10'h111, 16'h7777);
    tick();
    REQ = 1'b0;
    tick();
    check("ar_wait_req_n", MEM_REQ_n, 1'b0);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check_reset_outputs("ar");
    MEM_ACK_n = 1'b0;
    @(negedge sysclk);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ar_post_dt_n", DT_n, 1'b1);
      check("ar_post_iox_n", IOXERR_n, 1'b1);
      check("ar_post_busy", BUSY, 1'b0);
    end
    MEM_ACK_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
